// File: rtl/debug_mem_dumper_if.sv
// Handshake and bus bundle between the debug memory dumper, the MEMORY stage debug
// read port and the UART transmitter.
interface debug_mem_dumper_if #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_MEM_ADDR = 5,
  parameter int unsigned NB_BYTE     = 8
);
  logic                   i_start;
  logic [NB_DATA-1:0]     i_read_dm;
  logic                   i_tx_ready;
  logic                   o_debug_unit_flag;
  logic                   o_mem_read_enable;
  logic [NB_MEM_ADDR-1:0] o_mem_read_addr;
  logic [NB_BYTE-1:0]     o_tx_data;
  logic                   o_tx_valid;
  logic                   o_busy;
  logic                   o_done;

  modport master (
    input  i_start, i_read_dm, i_tx_ready,
    output o_debug_unit_flag, o_mem_read_enable, o_mem_read_addr,
           o_tx_data, o_tx_valid, o_busy, o_done
  );

  modport slave (
    output i_start, i_read_dm, i_tx_ready,
    input  o_debug_unit_flag, o_mem_read_enable, o_mem_read_addr,
           o_tx_data, o_tx_valid, o_busy, o_done
  );
endinterface

// File: rtl/debug_mem_dumper.sv
// Sweeps the whole data memory through the debug read port and streams each word MSB-first
// as bytes to the UART. Define DEBUG_DUMP_CHECKSUM_EN to append a trailing XOR checksum byte.
module debug_mem_dumper #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_MEM_ADDR = 5,
  parameter int unsigned NB_BYTE     = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  debug_mem_dumper_if.master    bus
);
  localparam int unsigned NB_BYTES = NB_DATA / NB_BYTE;
  localparam int unsigned NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_IDX-1:0]      LAST_IDX = NB_IDX'(NB_BYTES - 1);
  localparam logic [NB_MEM_ADDR-1:0] TOP_ADDR = '1;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, REQ, LATCH, SEND, CSUM, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, REQ, LATCH, SEND, DONE} state_e;
`endif

  state_e                 state_q, state_d;
  logic [NB_MEM_ADDR-1:0] addr_q, addr_d;
  logic [NB_IDX-1:0]      idx_q, idx_d;
  logic [NB_DATA-1:0]     word_q, word_d;
  logic                   flag_q, flag_d;
  logic                   ren_q, ren_d;
  logic [NB_MEM_ADDR-1:0] raddr_q, raddr_d;
  logic [NB_BYTE-1:0]     tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]     csum_q, csum_d;
`endif

  // Byte idx of a word, byte 0 being the most significant
  function automatic logic [NB_BYTE-1:0] pick_byte(input logic [NB_DATA-1:0] w,
                                                   input logic [NB_IDX-1:0]  idx);
    pick_byte = '0;
    for (int unsigned i = 0; i < NB_BYTES; i++)
      if (NB_IDX'(i) == idx) pick_byte = w[NB_DATA-1-i*NB_BYTE -: NB_BYTE];
  endfunction

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      flag_q     <= 1'b0;
      ren_q      <= 1'b0;
      raddr_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      flag_q     <= flag_d;
      ren_q      <= ren_d;
      raddr_q    <= raddr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next state; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    word_d  = word_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: if (bus.i_start) begin
        state_d = REQ;
        addr_d  = '0;
        idx_d   = '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        csum_d  = '0;
`endif
      end
      REQ: state_d = LATCH;
      LATCH: begin
        word_d  = bus.i_read_dm;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: if (bus.i_tx_ready) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
        csum_d = csum_q ^ tx_data_q;
`endif
        if (idx_q == LAST_IDX) begin
          if (addr_q == TOP_ADDR) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = REQ;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef DEBUG_DUMP_CHECKSUM_EN
      CSUM: if (bus.i_tx_ready) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    flag_d     = (state_d != IDLE) && (state_d != DONE);
    ren_d      = (state_d == REQ) || (state_d == LATCH);
    raddr_d    = ren_d ? addr_d : '0;
    tx_valid_d = (state_d == SEND);
    tx_data_d  = '0;
    if (state_d == SEND) tx_data_d = pick_byte(word_d, idx_d);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    if (state_d == CSUM) begin
      tx_valid_d = 1'b1;
      tx_data_d  = csum_d;
    end
`endif
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.o_debug_unit_flag = flag_q;
  assign bus.o_mem_read_enable = ren_q;
  assign bus.o_mem_read_addr   = raddr_q;
  assign bus.o_tx_data         = tx_data_q;
  assign bus.o_tx_valid        = tx_valid_q;
  assign bus.o_busy            = busy_q;
  assign bus.o_done            = done_q;
endmodule

// File: tb/tb_debug_mem_dumper.sv
// Scoreboard bench for debug_mem_dumper: a reference model queues the expected byte stream,
// a negedge monitor pops and compares on every handshake and checks protocol properties.
`timescale 1ns/1ps
module tb_debug_mem_dumper;
  localparam int unsigned NB_DATA     = 32;
  localparam int unsigned NB_MEM_ADDR = 5;
  localparam int unsigned NB_BYTE     = 8;
  localparam int unsigned DEPTH       = 1 << NB_MEM_ADDR;
  localparam int unsigned BPW         = NB_DATA / NB_BYTE;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam int unsigned CSUM_N = 1;
`else
  localparam int unsigned CSUM_N = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_mem_dumper_if #(.NB_DATA(NB_DATA), .NB_MEM_ADDR(NB_MEM_ADDR), .NB_BYTE(NB_BYTE)) bus();

  debug_mem_dumper #(.NB_DATA(NB_DATA), .NB_MEM_ADDR(NB_MEM_ADDR), .NB_BYTE(NB_BYTE)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  logic [NB_DATA-1:0] mem [DEPTH];
  assign bus.i_read_dm = mem[bus.o_mem_read_addr];

  int checks = 0;
  int errors = 0;
  logic [NB_BYTE-1:0] exp_q [$];
  int ready_mode = 0;
  int bytes_seen, done_cnt, flag_cycles, busy_cycles;
  int cyc = 0, last_pop_cyc = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  // Reference model: the stream is every word, MSB byte first, plus optional XOR of all bytes
  task automatic push_expected();
    logic [NB_BYTE-1:0] x;
    logic [NB_BYTE-1:0] b;
    x = '0;
    for (int a = 0; a < int'(DEPTH); a++)
      for (int k = 0; k < int'(BPW); k++) begin
        b = NB_BYTE'(mem[a] >> (NB_DATA - NB_BYTE * (k + 1)));
        exp_q.push_back(b);
        x = x ^ b;
      end
    if (CSUM_N != 0) exp_q.push_back(x);
  endtask

  // Ready driver: 0 = always ready, 1 = repeating 1,0,0, 2 = random
  initial begin
    int ph;
    ph = 0;
    bus.i_tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.i_tx_ready = 1'b1;
        1:       bus.i_tx_ready = (ph == 0);
        default: bus.i_tx_ready = ($urandom_range(0, 2) != 0);
      endcase
      ph = (ph + 1) % 3;
    end
  end

  // Monitor
  initial begin
    bit held_valid, prev_done;
    logic [NB_BYTE-1:0] held_data, e;
    int en_run;
    held_valid = 0; prev_done = 0; en_run = 0; held_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_valid = 0; prev_done = 0; en_run = 0;
      end else begin
        cyc++;
        if (prev_done) chk(!bus.o_busy, "busy_after_done", 32'(bus.o_busy), 0);
        if (bus.o_done) begin
          done_cnt++;
          chk(cyc == last_pop_cyc + 1, "done_latency", 32'(cyc - last_pop_cyc), 1);
        end
        if (bus.o_busy) busy_cycles++;
        if (bus.o_debug_unit_flag) flag_cycles++;
        chk(bus.o_debug_unit_flag == (bus.o_busy && !bus.o_done), "flag_decode",
            32'(bus.o_debug_unit_flag), 32'(bus.o_busy && !bus.o_done));
        if (bus.o_mem_read_enable) begin
          chk(int'(bus.o_mem_read_addr) == bytes_seen / int'(BPW), "read_addr",
              32'(bus.o_mem_read_addr), 32'(bytes_seen / int'(BPW)));
          en_run++;
        end else if (en_run != 0) begin
          chk(en_run == 2, "addr_hold_cycles", 32'(en_run), 2);
          en_run = 0;
        end
        if (held_valid) begin
          chk(bus.o_tx_valid, "valid_hold", 32'(bus.o_tx_valid), 1);
          chk(bus.o_tx_data == held_data, "data_hold", 32'(bus.o_tx_data), 32'(held_data));
        end
        held_valid = bus.o_tx_valid && !bus.i_tx_ready;
        held_data  = bus.o_tx_data;
        if (bus.o_tx_valid && bus.i_tx_ready) begin
          if (exp_q.size() == 0) begin
            chk(0, "unexpected_byte", 32'(bus.o_tx_data), 0);
          end else begin
            e = exp_q.pop_front();
            chk(bus.o_tx_data == e, "tx_byte", 32'(bus.o_tx_data), 32'(e));
          end
          bytes_seen++;
          last_pop_cyc = cyc;
        end
        prev_done = bus.o_done;
      end
    end
  end

  task automatic clear_counts();
    bytes_seen = 0; done_cnt = 0; flag_cycles = 0; busy_cycles = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.i_start = 1'b1;
    @(posedge clk); #1 bus.i_start = 1'b0;
  endtask

  task automatic run_dump(input int mode, input bit extra_starts);
    int n;
    ready_mode = mode;
    exp_q.delete();
    push_expected();
    clear_counts();
    pulse_start();
    for (n = 0; n < 20000 && done_cnt == 0; n++) begin
      @(posedge clk); #1;
      bus.i_start = extra_starts && bytes_seen >= 5 * int'(BPW) && bytes_seen < 6 * int'(BPW)
                    && ($urandom_range(0, 1) == 1);
    end
    bus.i_start = 1'b0;
    chk(done_cnt != 0, "done_timeout", 32'(n), 20000);
    repeat (6) @(posedge clk);
    chk(done_cnt == 1, "done_count", 32'(done_cnt), 1);
    chk(exp_q.size() == 0, "bytes_missing", 32'(exp_q.size()), 0);
    chk(bytes_seen == int'(DEPTH * BPW + CSUM_N), "byte_count", 32'(bytes_seen), DEPTH * BPW + CSUM_N);
    chk(busy_cycles == flag_cycles + 1, "busy_cycles", 32'(busy_cycles), 32'(flag_cycles + 1));
    if (mode == 0)
      chk(flag_cycles == int'(DEPTH * (2 + BPW) + CSUM_N), "dump_cycles",
          32'(flag_cycles), DEPTH * (2 + BPW) + CSUM_N);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(!bus.o_debug_unit_flag, {tag, "_flag"}, 32'(bus.o_debug_unit_flag), 0);
    chk(!bus.o_mem_read_enable, {tag, "_ren"}, 32'(bus.o_mem_read_enable), 0);
    chk(bus.o_mem_read_addr == '0, {tag, "_addr"}, 32'(bus.o_mem_read_addr), 0);
    chk(bus.o_tx_data == '0, {tag, "_data"}, 32'(bus.o_tx_data), 0);
    chk(!bus.o_tx_valid, {tag, "_valid"}, 32'(bus.o_tx_valid), 0);
    chk(!bus.o_busy, {tag, "_busy"}, 32'(bus.o_busy), 0);
    chk(!bus.o_done, {tag, "_done"}, 32'(bus.o_done), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.i_start = 1'b0;
    for (int a = 0; a < int'(DEPTH); a++) mem[a] = 32'hA0A0_0000 + 32'(a);
    #12;
    check_outputs_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Incrementing pattern, always ready
    run_dump(0, 0);

    // Backpressure with fixed ready pattern
    for (int a = 0; a < int'(DEPTH); a++) mem[a] = $urandom;
    mem[0] = 32'h1122_3344;
    run_dump(1, 0);

    // Random ready, stray start pulses during word 5
    for (int a = 0; a < int'(DEPTH); a++) mem[a] = $urandom;
    run_dump(2, 1);

    // Reset in SEND of word 10, byte 2
    ready_mode = 0;
    exp_q.delete();
    push_expected();
    clear_counts();
    pulse_start();
    for (n = 0; n < 2000; n++) begin
      @(posedge clk); #3;
      if (bytes_seen == 10 * int'(BPW) + 2 && bus.o_tx_valid) break;
    end
    chk(n < 2000, "reset_point_timeout", 32'(n), 2000);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int a = 0; a < int'(DEPTH); a++) mem[a] = $urandom;
    run_dump(2, 0);

    // Uniform image: checksum (when enabled) and done latency
    for (int a = 0; a < int'(DEPTH); a++) mem[a] = 32'h0102_0304;
    run_dump(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
